// File: rtl/key_move_scheduler.sv
// Decodes per-player move keys from four USB keycode slots, generates press and
// DAS/ARR auto-repeat events on frame ticks, and issues them one at a time per player.
module key_move_scheduler #(
  parameter int unsigned DAS_FRAMES = 10,
  parameter int unsigned ARR_FRAMES = 3
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [31:0] keycode,
  input  logic        frame_tick,
  input  logic        move_ready1,
  input  logic        move_ready2,
  output logic        move_valid1,
  output logic [2:0]  move_cmd1,
  output logic        move_valid2,
  output logic [2:0]  move_cmd2
);

  typedef enum logic {IDLE, OFFER} state_t;

  localparam logic [5:0] DAS_LOAD = 6'(DAS_FRAMES);
  localparam logic [5:0] ARR_LOAD = 6'(ARR_FRAMES);

  logic [1:0][4:0] held_d, held_q;
  logic [1:0][4:0] prev_d, prev_q;
  logic [1:0][4:0] pending_d, pending_q;
  logic [5:0]      das_d [2][5];
  logic [5:0]      das_q [2][5];
  state_t          state_d [2];
  state_t          state_q [2];
  logic [2:0]      cmd_d [2];
  logic [2:0]      cmd_q [2];
  logic [1:0]      ready;

  // Key index k doubles as the move command encoding: 0 L, 1 R, 2 DOWN, 3 ROT_L, 4 ROT_R.
  function automatic logic [7:0] key_code(input int unsigned p, input int unsigned k);
    logic [7:0] c;
    c = '0;
    case (p * 5 + k)
      0: c = 8'h04;
      1: c = 8'h07;
      2: c = 8'h16;
      3: c = 8'h14;
      4: c = 8'h08;
      5: c = 8'h50;
      6: c = 8'h4F;
      7: c = 8'h51;
      8: c = 8'h36;
      9: c = 8'h37;
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] pick(input logic [4:0] pend);
    logic [2:0] c;
    if (pend[4])      c = 3'd4;
    else if (pend[3]) c = 3'd3;
    else if (pend[0]) c = 3'd0;
    else if (pend[1]) c = 3'd1;
    else              c = 3'd2;
    return c;
  endfunction

  always_comb begin
    held_d = '0;
    for (int unsigned p = 0; p < 2; p++)
      for (int unsigned k = 0; k < 5; k++)
        for (int unsigned s = 0; s < 4; s++)
          if (keycode[8*s +: 8] == key_code(p, k)) held_d[p][k] = 1'b1;
  end

  assign ready = {move_ready2, move_ready1};

  always_comb begin
    prev_d    = prev_q;
    pending_d = pending_q;
    das_d     = das_q;
    state_d   = state_q;
    cmd_d     = cmd_q;
    for (int unsigned p = 0; p < 2; p++) begin
      if (state_q[p] == OFFER) begin
        if (ready[p]) begin
          pending_d[p][cmd_q[p]] = 1'b0;
          state_d[p]             = IDLE;
        end
      end else if (pending_q[p] != '0) begin
        cmd_d[p]   = pick(pending_q[p]);
        state_d[p] = OFFER;
      end
    end
    // Tick updates come after the handshake clear so a same-cycle set wins.
    if (frame_tick) begin
      prev_d = held_q;
      for (int unsigned p = 0; p < 2; p++) begin
        for (int unsigned k = 0; k < 5; k++) begin
          if (held_q[p][k] && !prev_q[p][k]) begin
            pending_d[p][k] = 1'b1;
            das_d[p][k]     = DAS_LOAD;
          end else if (held_q[p][k]) begin
            if (k < 3 && das_q[p][k] == 6'd1) begin
              pending_d[p][k] = 1'b1;
              das_d[p][k]     = ARR_LOAD;
            end else if (das_q[p][k] != '0) begin
              das_d[p][k] = das_q[p][k] - 6'd1;
            end
          end else begin
            das_d[p][k] = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      held_q    <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      das_q     <= '{default: '0};
      state_q   <= '{default: IDLE};
      cmd_q     <= '{default: '0};
    end else begin
      held_q    <= held_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      das_q     <= das_d;
      state_q   <= state_d;
      cmd_q     <= cmd_d;
    end
  end

  assign move_valid1 = (state_q[0] == OFFER);
  assign move_cmd1   = cmd_q[0];
  assign move_valid2 = (state_q[1] == OFFER);
  assign move_cmd2   = cmd_q[1];

endmodule

// File: tb/tb_key_move_scheduler.sv
// Scoreboard bench for key_move_scheduler: expected moves are queued per player
// when keys are driven and checked as each handshake completes.
module tb_key_move_scheduler;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [31:0] keycode = '0;
  logic        frame_tick = 1'b0;
  logic        move_ready1 = 1'b1;
  logic        move_ready2 = 1'b1;
  logic        move_valid1, move_valid2;
  logic [2:0]  move_cmd1, move_cmd2;

  int checks = 0;
  int errors = 0;
  int acc1 = 0;
  int acc2 = 0;
  logic [2:0] q1[$];
  logic [2:0] q2[$];

  key_move_scheduler #(.DAS_FRAMES(10), .ARR_FRAMES(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_tick(frame_tick),
    .move_ready1(move_ready1), .move_ready2(move_ready2),
    .move_valid1(move_valid1), .move_cmd1(move_cmd1),
    .move_valid2(move_valid2), .move_cmd2(move_cmd2)
  );

  always #5 Clk = ~Clk;

  task automatic monitor();
    logic pv1 = 1'b0, pr1 = 1'b0, pv2 = 1'b0, pr2 = 1'b0;
    logic [2:0] pc1 = '0, pc2 = '0, e;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        pv1 = 1'b0;
        pv2 = 1'b0;
      end else begin
        if (pv1 && !pr1 && move_valid1) begin
          checks++;
          if (move_cmd1 !== pc1) begin
            errors++;
            $display("FAIL cmd1_stable: got %0d expected %0d", move_cmd1, pc1);
          end
        end
        if (pv2 && !pr2 && move_valid2) begin
          checks++;
          if (move_cmd2 !== pc2) begin
            errors++;
            $display("FAIL cmd2_stable: got %0d expected %0d", move_cmd2, pc2);
          end
        end
        if (move_valid1 && move_ready1) begin
          checks++;
          acc1++;
          if (q1.size() == 0) begin
            errors++;
            $display("FAIL p1_move: got cmd %0d expected no move", move_cmd1);
          end else begin
            e = q1.pop_front();
            if (move_cmd1 !== e) begin
              errors++;
              $display("FAIL p1_move: got cmd %0d expected %0d", move_cmd1, e);
            end
          end
        end
        if (move_valid2 && move_ready2) begin
          checks++;
          acc2++;
          if (q2.size() == 0) begin
            errors++;
            $display("FAIL p2_move: got cmd %0d expected no move", move_cmd2);
          end else begin
            e = q2.pop_front();
            if (move_cmd2 !== e) begin
              errors++;
              $display("FAIL p2_move: got cmd %0d expected %0d", move_cmd2, e);
            end
          end
        end
        pv1 = move_valid1; pr1 = move_ready1; pc1 = move_cmd1;
        pv2 = move_valid2; pr2 = move_ready2; pc2 = move_cmd2;
      end
    end
  endtask

  task automatic tick_frame();
    @(posedge Clk); #1 frame_tick = 1'b1;
    @(posedge Clk); #1 frame_tick = 1'b0;
    repeat (8) @(posedge Clk);
    #1;
  endtask

  task automatic check_drained(input string name, input int got1, input int exp1,
                               input int got2, input int exp2);
    checks++;
    if (got1 != exp1 || got2 != exp2 || q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL %s: moves p1 %0d p2 %0d left %0d/%0d, expected p1 %0d p2 %0d left 0/0",
               name, got1, got2, q1.size(), q2.size(), exp1, exp2);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({move_valid1, move_valid2, move_cmd1, move_cmd2} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got v1 %b v2 %b c1 %0d c2 %0d expected all 0",
               move_valid1, move_valid2, move_cmd1, move_cmd2);
    end
    #1 Reset_n = 1'b1;
    repeat (4) @(posedge Clk);
    #1;
    checks++;
    if (move_valid1 !== 1'b0 || move_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got v1 %b v2 %b expected 0 0", move_valid1, move_valid2);
    end
  endtask

  task automatic test_press();
    int a1 = acc1, a2 = acc2, n1 = 0, n2 = 0;
    keycode = 32'h0000_0004;
    q1.push_back(3'd0);
    @(posedge Clk); #1 frame_tick = 1'b1;
    @(posedge Clk); #1 frame_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (move_valid1) n1++;
      if (move_valid2) n2++;
    end
    checks++;
    if (n1 != 1 || n2 != 0) begin
      errors++;
      $display("FAIL press_valid_cycles: got v1 %0d v2 %0d expected 1 0", n1, n2);
    end
    keycode = '0;
    tick_frame();
    check_drained("press", acc1 - a1, 1, acc2 - a2, 0);
  endtask

  task automatic test_auto_repeat();
    int a1 = acc1;
    keycode = 32'h0000_0007;
    repeat (5) q1.push_back(3'd1);
    repeat (20) tick_frame();
    keycode = '0;
    tick_frame();
    check_drained("auto_repeat", acc1 - a1, 5, 0, 0);
  endtask

  task automatic test_rotation();
    int a1 = acc1;
    keycode = 32'h0814_0000;
    q1.push_back(3'd4);
    q1.push_back(3'd3);
    repeat (30) tick_frame();
    keycode = '0;
    tick_frame();
    check_drained("rotation_no_repeat", acc1 - a1, 2, 0, 0);
  endtask

  task automatic test_stall();
    int a2 = acc2;
    move_ready2 = 1'b0;
    keycode = 32'h0000_0050;
    tick_frame();
    keycode = 32'h0000_0051;
    tick_frame();
    checks++;
    if (move_valid2 !== 1'b1 || move_cmd2 !== 3'd0) begin
      errors++;
      $display("FAIL stall_hold: got v2 %b c2 %0d expected 1 0", move_valid2, move_cmd2);
    end
    q2.push_back(3'd0);
    q2.push_back(3'd2);
    move_ready2 = 1'b1;
    repeat (10) @(posedge Clk);
    #1;
    keycode = '0;
    tick_frame();
    check_drained("stall_release", 0, 0, acc2 - a2, 2);
  endtask

  task automatic test_both_players();
    int a1 = acc1, a2 = acc2;
    bit both = 1'b0;
    keycode = 32'h4F00_0016;
    q1.push_back(3'd2);
    q2.push_back(3'd1);
    @(posedge Clk); #1 frame_tick = 1'b1;
    @(posedge Clk); #1 frame_tick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (move_valid1 && move_valid2) both = 1'b1;
    end
    checks++;
    if (!both) begin
      errors++;
      $display("FAIL both_valid_same_cycle: got 0 expected 1");
    end
    keycode = '0;
    tick_frame();
    check_drained("both_players", acc1 - a1, 1, acc2 - a2, 1);
  endtask

  task automatic test_async_reset();
    int a1;
    move_ready1 = 1'b0;
    keycode = 32'h0000_0004;
    tick_frame();
    checks++;
    if (move_valid1 !== 1'b1) begin
      errors++;
      $display("FAIL offer_before_reset: got v1 %b expected 1", move_valid1);
    end
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    checks++;
    if (move_valid1 !== 1'b0 || move_cmd1 !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: got v1 %b c1 %0d expected 0 0", move_valid1, move_cmd1);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    move_ready1 = 1'b1;
    a1 = acc1;
    q1.push_back(3'd0);
    tick_frame();
    keycode = '0;
    tick_frame();
    check_drained("press_after_reset", acc1 - a1, 1, 0, 0);
  endtask

  initial begin
    fork
      monitor();
      begin
        test_reset();
        test_press();
        test_auto_repeat();
        test_rotation();
        test_stall();
        test_both_players();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join
  end

endmodule
